// File: rtl/obi_cpu_port_arbiter.sv
// Shares one OBI master port between the core's instruction and data ports,
// holding each request stable until granted and routing responses back in order.
package obi_arb_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_cpu_port_arbiter
    import obi_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit FIXED_PRIO      = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  obi_req_t   instr_req_i,
    output obi_resp_t  instr_resp_o,
    input  obi_req_t   data_req_i,
    output obi_resp_t  data_resp_o,
    output obi_req_t   bus_req_o,
    input  obi_resp_t  bus_resp_i,
    output logic [3:0] outstanding_o,
    output logic       unexpected_rvalid_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [3:0]       FULL_COUNT = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        LOCKED_INSTR,
        LOCKED_DATA
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]       count_q;
    logic             fifo_mem_q [MAX_OUTSTANDING];

    logic sel;
    logic fifo_full, fifo_empty;
    logic bus_req_valid, bus_gnt;
    logic push, pop, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full     = (count_q == FULL_COUNT);
    assign fifo_empty    = (count_q == 4'd0);
    assign outstanding_o = count_q;

    // A locked requester keeps the port until granted so its address phase stays stable.
    always_comb begin
        sel = 1'b0;
        unique case (state_q)
            LOCKED_INSTR: sel = 1'b0;
            LOCKED_DATA:  sel = 1'b1;
            default: begin
                if (instr_req_i.req && data_req_i.req) begin
                    sel = FIXED_PRIO ? 1'b1 : ~last_grant_q;
                end else begin
                    sel = data_req_i.req;
                end
            end
        endcase
    end

    always_comb begin
        bus_req_o     = sel ? data_req_i : instr_req_i;
        bus_req_valid = (sel ? data_req_i.req : instr_req_i.req) & ~fifo_full & ~rst_i;
        bus_req_o.req = bus_req_valid;
        bus_gnt       = bus_resp_i.gnt & bus_req_valid;

        push = bus_gnt;
        pop  = bus_resp_i.rvalid & ~fifo_empty & ~rst_i;
        head = fifo_mem_q[rd_ptr_q];

        instr_resp_o        = '0;
        instr_resp_o.rdata  = bus_resp_i.rdata;
        instr_resp_o.gnt    = bus_gnt & ~sel;
        instr_resp_o.rvalid = pop & ~head;

        data_resp_o         = '0;
        data_resp_o.rdata   = bus_resp_i.rdata;
        data_resp_o.gnt     = bus_gnt & sel;
        data_resp_o.rvalid  = pop & head;

        unexpected_rvalid_o = bus_resp_i.rvalid & fifo_empty & ~rst_i;

        state_d = IDLE;
        if (!bus_gnt && bus_req_valid) begin
            state_d = sel ? LOCKED_DATA : LOCKED_INSTR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= 4'd0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q     <= ptr_inc(wr_ptr_q);
                last_grant_q <= sel;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Requester ids only matter while counted, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_obi_cpu_port_arbiter.sv
// Scoreboard bench: stimulus queues expected grant/response events, a negedge
// monitor pops and compares them whenever either arbiter presents one.
module tb_obi_cpu_port_arbiter;
    import obi_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    obi_req_t  [1:0] instr_req, data_req;
    obi_resp_t [1:0] bus_resp;

    obi_req_t   bus_req_rr, bus_req_fp;
    obi_resp_t  instr_resp_rr, instr_resp_fp, data_resp_rr, data_resp_fp;
    logic [3:0] outstanding_rr, outstanding_fp;
    logic       unexp_rr, unexp_fp;

    obi_cpu_port_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b0)) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req[0]), .instr_resp_o(instr_resp_rr),
        .data_req_i(data_req[0]), .data_resp_o(data_resp_rr),
        .bus_req_o(bus_req_rr), .bus_resp_i(bus_resp[0]),
        .outstanding_o(outstanding_rr), .unexpected_rvalid_o(unexp_rr)
    );

    obi_cpu_port_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b1)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req[1]), .instr_resp_o(instr_resp_fp),
        .data_req_i(data_req[1]), .data_resp_o(data_resp_fp),
        .bus_req_o(bus_req_fp), .bus_resp_i(bus_resp[1]),
        .outstanding_o(outstanding_fp), .unexpected_rvalid_o(unexp_fp)
    );

    typedef struct {
        int          cyc;
        int          dut;
        int          who;
        logic [31:0] val;
    } ev_t;

    ev_t gnt_q[$];
    ev_t rv_q[$];
    ev_t ux_q[$];

    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expectEv(input int kind, input int d, input int who, input logic [31:0] val);
        ev_t e;
        e.cyc = cyc;
        e.dut = d;
        e.who = who;
        e.val = val;
        case (kind)
            0:       gnt_q.push_back(e);
            1:       rv_q.push_back(e);
            default: ux_q.push_back(e);
        endcase
    endtask

    task automatic matchEvent(input int kind, input int d, input int who, input logic [31:0] val);
        ev_t   e;
        int    sz;
        string nm;
        case (kind)
            0:       begin nm = "gnt";               sz = gnt_q.size(); end
            1:       begin nm = "rvalid";            sz = rv_q.size();  end
            default: begin nm = "unexpected_rvalid"; sz = ux_q.size();  end
        endcase
        if (sz == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_extra: dut %0d requester %0d raised it at cycle %0d, expected none", nm, d, who, cyc);
            return;
        end
        case (kind)
            0:       e = gnt_q.pop_front();
            1:       e = rv_q.pop_front();
            default: e = ux_q.pop_front();
        endcase
        checkOutput({nm, "_cycle"}, cyc, e.cyc);
        checkOutput({nm, "_dut"}, d, e.dut);
        if (kind != 2) begin
            checkOutput({nm, "_requester"}, who, e.who);
            checkOutput({nm, "_value"}, val, e.val);
        end
    endtask

    obi_resp_t  mon_ir, mon_dr;
    obi_req_t   mon_br;
    logic       mon_ux;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mon_ir = (d == 0) ? instr_resp_rr : instr_resp_fp;
            mon_dr = (d == 0) ? data_resp_rr  : data_resp_fp;
            mon_br = (d == 0) ? bus_req_rr    : bus_req_fp;
            mon_ux = (d == 0) ? unexp_rr      : unexp_fp;
            if (mon_ir.gnt)    matchEvent(0, d, 0, mon_br.addr);
            if (mon_dr.gnt)    matchEvent(0, d, 1, mon_br.addr);
            if (mon_ir.rvalid) matchEvent(1, d, 0, mon_ir.rdata);
            if (mon_dr.rvalid) matchEvent(1, d, 1, mon_dr.rdata);
            if (mon_ux)        matchEvent(2, d, 0, 32'h0);
        end
    end

    task automatic clearInputs();
        instr_req = '0;
        data_req  = '0;
        bus_resp  = '0;
    endtask

    task automatic applyStimulus(input int d, input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic [31:0] daddr,
                                 input logic bgnt, input logic brv, input logic [31:0] brdata);
        clearInputs();
        instr_req[d].req    = ireq;
        instr_req[d].be     = 4'hF;
        instr_req[d].addr   = iaddr;
        data_req[d].req     = dreq;
        data_req[d].we      = 1'b1;
        data_req[d].be      = 4'hF;
        data_req[d].addr    = daddr;
        data_req[d].wdata   = ~daddr;
        bus_resp[d].gnt     = bgnt;
        bus_resp[d].rvalid  = brv;
        bus_resp[d].rdata   = brdata;
    endtask

    task automatic checkCycle(input int d, input logic exp_req, input logic [31:0] exp_addr, input logic [3:0] exp_out);
        obi_req_t   br;
        logic [3:0] out;
        @(negedge clk);
        br  = (d == 0) ? bus_req_rr : bus_req_fp;
        out = (d == 0) ? outstanding_rr : outstanding_fp;
        checkOutput("bus_req", br.req, exp_req);
        if (exp_req) checkOutput("bus_addr", br.addr, exp_addr);
        checkOutput("outstanding", out, exp_out);
        @(posedge clk);
        #1;
    endtask

    // Requests, grants and responses are all asserted during reset to prove they are masked.
    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            instr_req[d].req   = 1'b1;
            data_req[d].req    = 1'b1;
            bus_resp[d].gnt    = 1'b1;
            bus_resp[d].rvalid = 1'b1;
        end
        @(negedge clk);
        checkOutput("reset_bus_req_rr", bus_req_rr.req, 1'b0);
        checkOutput("reset_bus_req_fp", bus_req_fp.req, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearInputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;

        // single instruction fetch
        doReset();
        applyStimulus(0, 1, 32'h180, 0, 0, 1, 0, 0);
        expectEv(0, 0, 0, 32'h180);
        checkCycle(0, 1, 32'h180, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        expectEv(1, 0, 0, 32'hDEADBEEF);
        checkCycle(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkCycle(0, 0, 0, 0);

        // round robin with both ports requesting
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 32'h100, 1, 32'h200, 1, i > 0, 32'hA000_0000 + i - 1);
            expectEv(0, 0, i % 2, (i % 2 == 1) ? 32'h200 : 32'h100);
            if (i > 0) expectEv(1, 0, (i - 1) % 2, 32'hA000_0000 + i - 1);
            checkCycle(0, 1, (i % 2 == 1) ? 32'h200 : 32'h100, (i == 0) ? 4'd0 : 4'd1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hA000_0003);
        expectEv(1, 0, 1, 32'hA000_0003);
        checkCycle(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkCycle(0, 0, 0, 0);

        // fixed priority to data
        doReset();
        applyStimulus(1, 1, 32'h110, 1, 32'h210, 1, 0, 0);
        expectEv(0, 1, 1, 32'h210);
        checkCycle(1, 1, 32'h210, 0);
        applyStimulus(1, 1, 32'h110, 1, 32'h214, 1, 1, 32'hB0);
        expectEv(0, 1, 1, 32'h214);
        expectEv(1, 1, 1, 32'hB0);
        checkCycle(1, 1, 32'h214, 1);
        applyStimulus(1, 1, 32'h110, 0, 0, 1, 1, 32'hB1);
        expectEv(0, 1, 0, 32'h110);
        expectEv(1, 1, 1, 32'hB1);
        checkCycle(1, 1, 32'h110, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hB2);
        expectEv(1, 1, 0, 32'hB2);
        checkCycle(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkCycle(1, 0, 0, 0);

        // lock: prior instr grant makes round robin favour data, lock must override it
        doReset();
        applyStimulus(0, 1, 32'h10, 0, 0, 1, 0, 0);
        expectEv(0, 0, 0, 32'h10);
        checkCycle(0, 1, 32'h10, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h11);
        expectEv(1, 0, 0, 32'h11);
        checkCycle(0, 0, 0, 1);
        applyStimulus(0, 1, 32'h300, 0, 0, 0, 0, 0);
        checkCycle(0, 1, 32'h300, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 32'h300, 1, 32'h400, 0, 0, 0);
            checkCycle(0, 1, 32'h300, 0);
        end
        applyStimulus(0, 1, 32'h300, 1, 32'h400, 1, 0, 0);
        expectEv(0, 0, 0, 32'h300);
        checkCycle(0, 1, 32'h300, 0);
        applyStimulus(0, 0, 0, 1, 32'h400, 1, 0, 0);
        expectEv(0, 0, 1, 32'h400);
        checkCycle(0, 1, 32'h400, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hC0);
        expectEv(1, 0, 0, 32'hC0);
        checkCycle(0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hC1);
        expectEv(1, 0, 1, 32'hC1);
        checkCycle(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkCycle(0, 0, 0, 0);

        // back-pressure from a full response FIFO
        doReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 32'h500, 0, 0, 1, 0, 0);
            expectEv(0, 0, 0, 32'h500);
            checkCycle(0, 1, 32'h500, 4'(i));
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 32'h500, 0, 0, 1, 0, 0);
            checkCycle(0, 0, 0, 2);
        end
        applyStimulus(0, 1, 32'h500, 0, 0, 1, 1, 32'hD0);
        expectEv(1, 0, 0, 32'hD0);
        checkCycle(0, 0, 0, 2);
        applyStimulus(0, 1, 32'h500, 0, 0, 1, 0, 0);
        expectEv(0, 0, 0, 32'h500);
        checkCycle(0, 1, 32'h500, 1);
        applyStimulus(0, 1, 32'h500, 0, 0, 1, 0, 0);
        checkCycle(0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hD1);
        expectEv(1, 0, 0, 32'hD1);
        checkCycle(0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hD2);
        expectEv(1, 0, 0, 32'hD2);
        checkCycle(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkCycle(0, 0, 0, 0);

        // reset discards an in-flight transaction; its late response is unexpected
        applyStimulus(0, 1, 32'h600, 0, 0, 1, 0, 0);
        expectEv(0, 0, 0, 32'h600);
        checkCycle(0, 1, 32'h600, 0);
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
        expectEv(2, 0, 0, 32'h0);
        checkCycle(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkCycle(0, 0, 0, 0);

        checkOutput("gnt_events_left", gnt_q.size(), 0);
        checkOutput("rvalid_events_left", rv_q.size(), 0);
        checkOutput("unexpected_events_left", ux_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
